// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX-stage operand buses and the multiply/divide unit.
interface mult_div_unit_if;
  logic [31:0] A1;
  logic [31:0] A2;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A1, A2, MDUOp, Start, input Busy, HI, LO);
  modport slave  (input A1, A2, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the MIPS EX stage.
// Optional madd/maddu (MDUOp 110/111) enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             madd;
  logic             busy;
  logic [31:0]      hi;
  logic [31:0]      lo;

  logic signed [63:0] sa64, sb64;
  logic [63:0]        prod_s_c, prod_u_c;
  logic [31:0]        mag_a_c, mag_b_c, uq_c, ur_c;
  logic [63:0]        res_c;
  logic               launch_c;
  logic               madd_c;
  logic [CNT_W-1:0]   cyc_c;

  // Result datapath: everything an op needs is computed from the operands sampled at Start.
  always_comb begin
    sa64     = {{32{bus.A1[31]}}, bus.A1};
    sb64     = {{32{bus.A2[31]}}, bus.A2};
    prod_s_c = 64'(sa64 * sb64);
    prod_u_c = {32'd0, bus.A1} * {32'd0, bus.A2};
    mag_a_c  = bus.A1[31] ? 32'(-bus.A1) : bus.A1;
    mag_b_c  = bus.A2[31] ? 32'(-bus.A2) : bus.A2;
    uq_c     = 32'd0;
    ur_c     = 32'd0;
    res_c    = 64'd0;
    launch_c = 1'b0;
    madd_c   = 1'b0;
    cyc_c    = CNT_W'(MULT_CYCLES);
    case (bus.MDUOp)
      OP_MULT: begin
        res_c    = prod_s_c;
        launch_c = 1'b1;
      end
      OP_MULTU: begin
        res_c    = prod_u_c;
        launch_c = 1'b1;
      end
      OP_DIV: begin
        launch_c = 1'b1;
        cyc_c    = CNT_W'(DIV_CYCLES);
        if (bus.A2 == 32'd0) begin
          res_c = {bus.A1, 32'hFFFF_FFFF};
        end else begin
          // Divide magnitudes, then restore signs; this also covers 0x80000000 / -1.
          uq_c  = mag_a_c / mag_b_c;
          ur_c  = mag_a_c % mag_b_c;
          res_c = {(bus.A1[31] ? 32'(-ur_c) : ur_c),
                   ((bus.A1[31] ^ bus.A2[31]) ? 32'(-uq_c) : uq_c)};
        end
      end
      OP_DIVU: begin
        launch_c = 1'b1;
        cyc_c    = CNT_W'(DIV_CYCLES);
        if (bus.A2 == 32'd0) begin
          res_c = {bus.A1, 32'hFFFF_FFFF};
        end else begin
          uq_c  = bus.A1 / bus.A2;
          ur_c  = bus.A1 % bus.A2;
          res_c = {ur_c, uq_c};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res_c    = prod_s_c;
        launch_c = 1'b1;
        madd_c   = 1'b1;
      end
      OP_MADDU: begin
        res_c    = prod_u_c;
        launch_c = 1'b1;
        madd_c   = 1'b1;
      end
`else
      OP_MADD, OP_MADDU: begin
        launch_c = 1'b0;
      end
`endif
      default: begin
        launch_c = 1'b0;
      end
    endcase
  end

  // Control FSM; Start is only honoured in IDLE so an in-flight op can never be disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 64'd0;
      madd  <= 1'b0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (launch_c) begin
              pend  <= res_c;
              madd  <= madd_c;
              cnt   <= cyc_c;
              busy  <= 1'b1;
              state <= RUN;
            end else if (bus.MDUOp == OP_MTHI) begin
              hi <= bus.A1;
            end else if (bus.MDUOp == OP_MTLO) begin
              lo <= bus.A1;
            end
          end
        end
        RUN: begin
          if (cnt <= CNT_W'(1)) begin
            // Accumulate reads HI/LO at completion so madd sees their current value.
            {hi, lo} <= madd ? ({hi, lo} + pend) : pend;
            cnt      <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy;
  assign bus.HI   = hi;
  assign bus.LO   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed plan cases plus random ops against a longint model.
module tb_mult_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit_if mdu ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one op on the model HI/LO, plus expected Busy length.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    lat = 0;
    case (op)
      3'd0: begin p = longint'(sa * sb); {m_hi, m_lo} = p; lat = MC; end
      3'd1: begin p = ua * ub;           {m_hi, m_lo} = p; lat = MC; end
      3'd2: begin
        lat = DC;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        lat = DC;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: begin
`ifdef MDU_MADD_EN
        p   = (op == 3'd6) ? longint'(sa * sb) : ua * ub;
        acc = {m_hi, m_lo} + p;
        {m_hi, m_lo} = acc;
        lat = MC;
`else
        acc = {m_hi, m_lo};
        {m_hi, m_lo} = acc;
`endif
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu.MDUOp = op;
    mdu.A1    = a;
    mdu.A2    = b;
    mdu.Start = 1'b1;
    tick();
    mdu.Start = 1'b0;
    mdu.MDUOp = 3'($urandom);
    mdu.A1    = $urandom;
    mdu.A2    = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat, n;
    model(op, a, b, lat);
    issue(op, a, b);
    n = 0;
    while (mdu.Busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(lat));
    chk({tag, ".hi"}, mdu.HI, m_hi);
    chk({tag, ".lo"}, mdu.LO, m_lo);
  endtask

  initial begin
    int lat, n;
    logic [2:0]  op;
    logic [31:0] a, b;
    reset     = 1'b1;
    mdu.Start = 1'b0;
    mdu.MDUOp = 3'd0;
    mdu.A1    = 32'd0;
    mdu.A2    = 32'd0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    repeat (2) tick();
    chk("reset.busy", {31'd0, mdu.Busy}, 32'd0);
    chk("reset.hi", mdu.HI, 32'd0);
    chk("reset.lo", mdu.LO, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("plan.mult.hi", m_hi, 32'hFFFF_FFFF);
    run_op("multu_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2);
    run_op("divu_by0", 3'd3, 32'h1234, 32'd0);
    run_op("div_by0", 3'd2, 32'h8765_4321, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi", 3'd4, 32'hAAAA_5555, 32'h1111_1111);

    // Start while Busy must be ignored: mtlo then a second mult mid-flight.
    model(3'd0, 32'h0001_2345, 32'hFFFF_0003, lat);
    issue(3'd0, 32'h0001_2345, 32'hFFFF_0003);
    mdu.Start = 1'b1; mdu.MDUOp = 3'd5; mdu.A1 = 32'hDEAD_BEEF;
    tick();
    mdu.MDUOp = 3'd0; mdu.A1 = 32'h7777_7777; mdu.A2 = 32'h3333_3333;
    tick();
    mdu.Start = 1'b0;
    n = 2;
    while (mdu.Busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("ignore.busy_cycles", 32'(n), 32'(lat));
    chk("ignore.hi", mdu.HI, m_hi);
    chk("ignore.lo", mdu.LO, m_lo);
    tick();
    chk("ignore.quiet", {31'd0, mdu.Busy}, 32'd0);

    // Async reset on Busy cycle 3 discards the in-flight result.
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    tick();
    chk("rst_mid.busy_before", {31'd0, mdu.Busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.busy", {31'd0, mdu.Busy}, 32'd0);
    chk("rst_mid.hi", mdu.HI, 32'd0);
    chk("rst_mid.lo", mdu.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("rst_mid.no_late_hi", mdu.HI, 32'd0);
    chk("rst_mid.no_late_lo", mdu.LO, 32'd0);
    run_op("mult_after_rst", 3'd0, 32'h0000_0100, 32'h0000_0300);

    // madd/maddu, or no-op when the feature is compiled out.
    run_op("madd_set_hi", 3'd4, 32'd0, 32'd0);
    run_op("madd_set_lo", 3'd5, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu_1x1", 3'd7, 32'd1, 32'd1);
    run_op("madd_rand", 3'd6, $urandom, $urandom);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
